// File: rtl/mem_pkg.sv
// Shared types and constants for the 2-word x 8-bit memory initiator.
//   state_e     : controller FSM states
//   RW_WRITE/RW_READ : rw pin encoding shared by commands and the array
//   MEM_DATA_W / MEM_ADDR_W : array word and address widths
package mem_pkg;

  localparam int unsigned MEM_DATA_W = 8;
  localparam int unsigned MEM_ADDR_W = 1;
  localparam int unsigned CNT_W      = 3;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Command / response / array pin bundle for mem_access_ctrl.
//   master : command initiator (drives cmd_*, rsp_ready)
//   slave  : the controller (accepts cmd_*, returns rsp_*, drives mem_add/mem_rw/mem_i)
//   array  : the memory array (consumes mem_add/mem_rw/mem_i, returns mem_s)
interface mem_access_ctrl_if;
  import mem_pkg::*;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_rw;
  logic [MEM_ADDR_W-1:0] cmd_addr;
  logic [MEM_DATA_W-1:0] cmd_wdata;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic                  rsp_rw;
  logic [MEM_DATA_W-1:0] rsp_rdata;

  logic [MEM_ADDR_W-1:0] mem_add;
  logic                  mem_rw;
  logic [MEM_DATA_W-1:0] mem_i;
  logic [MEM_DATA_W-1:0] mem_s;

  modport master (
    output cmd_valid, cmd_rw, cmd_addr, cmd_wdata, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_rw, rsp_rdata
  );

  modport slave (
    input  cmd_valid, cmd_rw, cmd_addr, cmd_wdata, rsp_ready, mem_s,
    output cmd_ready, rsp_valid, rsp_rw, rsp_rdata, mem_add, mem_rw, mem_i
  );

  modport array (
    input  mem_add, mem_rw, mem_i,
    output mem_s
  );

endinterface

// File: rtl/mem_access_ctrl.sv
// Initiator for the 2x8 JK flip-flop memory array. Accepts one read/write
// command per valid/ready handshake, drives the array pins, and returns one
// response per command. Every output is a flop, so mem_rw (which gates the
// array clock) cannot glitch.
//   clk     : system clock
//   clear_n : synchronous reset, active low
//   bus     : slave side of mem_access_ctrl_if (cmd_*, rsp_*, mem_*)
//   RD_LAT  : cycles from driving a read address to sampling mem_s (1..7)
//   WR_LEN  : cycles mem_rw is held high for a write (1..7)
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned WR_LEN = 1
) (
  input logic               clk,
  input logic               clear_n,
  mem_access_ctrl_if.slave  bus
);

  localparam int unsigned DATA_W = MEM_DATA_W;
  localparam int unsigned ADDR_W = MEM_ADDR_W;

  state_e              state_q,     state_d;
  logic [CNT_W-1:0]    cnt_q,       cnt_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_rw_q,    rsp_rw_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [ADDR_W-1:0]   mem_add_q,   mem_add_d;
  logic                mem_rw_q,    mem_rw_d;
  logic [DATA_W-1:0]   mem_i_q,     mem_i_d;

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rw_d    = rsp_rw_q;
    rsp_rdata_d = rsp_rdata_q;
    mem_add_d   = mem_add_q;
    mem_rw_d    = mem_rw_q;
    mem_i_d     = mem_i_q;

    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          mem_add_d = bus.cmd_addr;
          if (bus.cmd_rw == RW_WRITE) begin
            mem_i_d  = bus.cmd_wdata;
            mem_rw_d = 1'b1;
            cnt_d    = CNT_W'(WR_LEN - 1);
            state_d  = WRITE;
          end else begin
            mem_rw_d = 1'b0;
            cnt_d    = CNT_W'(RD_LAT - 1);
            state_d  = READ;
          end
        end
      end
      WRITE: begin
        if (cnt_q == '0) begin
          mem_rw_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rw_d    = RW_WRITE;
          rsp_rdata_d = '0;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      READ: begin
        if (cnt_q == '0) begin
          rsp_valid_d = 1'b1;
          rsp_rw_d    = RW_READ;
          rsp_rdata_d = bus.mem_s;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Ready is registered, so it must reflect the state being entered.
    cmd_ready_d = (state_d == IDLE);
  end

  // State and output registers; reset also drops an in-flight write pulse.
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rw_q    <= 1'b0;
      rsp_rdata_q <= '0;
      mem_add_q   <= '0;
      mem_rw_q    <= 1'b0;
      mem_i_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rw_q    <= rsp_rw_d;
      rsp_rdata_q <= rsp_rdata_d;
      mem_add_q   <= mem_add_d;
      mem_rw_q    <= mem_rw_d;
      mem_i_q     <= mem_i_d;
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rw    = rsp_rw_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.mem_add   = mem_add_q;
  assign bus.mem_rw    = mem_rw_q;
  assign bus.mem_i     = mem_i_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl driving a behavioural 2x8 array. A transaction-
// level model (accept time + fixed latency, reference memory) predicts every
// output each cycle; directed sequences pin literal values.
module tb_mem_access_ctrl;
  import mem_pkg::*;

  localparam int RD_LAT_T = 2;
  localparam int WR_LEN_T = 3;

  logic clk;
  logic clear_n;
  int   errors = 0;
  int   checks = 0;

  mem_access_ctrl_if bif ();

  mem_access_ctrl #(.RD_LAT(RD_LAT_T), .WR_LEN(WR_LEN_T)) dut (
    .clk     (clk),
    .clear_n (clear_n),
    .bus     (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory array: flip-flops clock on clk & rw, output is the addressed word.
  logic [7:0] arr [2];
  always @(posedge clk) if (bif.mem_rw === 1'b1) arr[bif.mem_add] <= bif.mem_i;
  assign bif.mem_s = arr[bif.mem_add];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  bit         m_on = 0;
  bit         m_busy, m_is_wr, m_rsp_v, m_rsp_rw, m_mem_rw;
  logic [7:0] m_rsp_data, m_i;
  logic [0:0] m_add;
  logic [7:0] mdl_mem [2];
  int         edge_n = 0;
  int         m_acc;

  initial begin
    mdl_mem[0] = 8'h00;
    mdl_mem[1] = 8'h00;
  end

  always @(posedge clk) begin : model
    logic [7:0] rd;
    rd = mdl_mem[m_add];
    if (m_on && m_mem_rw) mdl_mem[m_add] = m_i;
    if (!clear_n) begin
      m_on = 1; m_busy = 0; m_is_wr = 0; m_rsp_v = 0; m_rsp_rw = 0;
      m_rsp_data = 8'h00; m_add = 1'b0; m_i = 8'h00;
    end else if (m_on) begin
      if (m_busy) begin
        if (edge_n - m_acc == (m_is_wr ? WR_LEN_T : RD_LAT_T)) begin
          m_busy = 0; m_rsp_v = 1; m_rsp_rw = m_is_wr;
          m_rsp_data = m_is_wr ? 8'h00 : rd;
        end
      end else if (m_rsp_v) begin
        if (bif.rsp_ready) m_rsp_v = 0;
      end else if (bif.cmd_valid) begin
        m_busy = 1; m_acc = edge_n; m_is_wr = bif.cmd_rw; m_add = bif.cmd_addr;
        if (bif.cmd_rw) m_i = bif.cmd_wdata;
      end
    end
    m_mem_rw = m_busy && m_is_wr;
    edge_n++;
  end

  // Per-cycle comparison plus a couple of observers, all at the quiet negedge.
  int  rw_hi_cnt = 0;
  int  rsp_cnt   = 0;
  bit  prev_rv   = 0;
  always @(negedge clk) begin
    if (m_on) begin
      chk("cmd_ready", 8'(bif.cmd_ready), 8'(!m_busy && !m_rsp_v));
      chk("rsp_valid", 8'(bif.rsp_valid), 8'(m_rsp_v));
      chk("rsp_rw",    8'(bif.rsp_rw),    8'(m_rsp_rw));
      chk("rsp_rdata", bif.rsp_rdata,     m_rsp_data);
      chk("mem_rw",    8'(bif.mem_rw),    8'(m_mem_rw));
      chk("mem_add",   8'(bif.mem_add),   8'(m_add));
      chk("mem_i",     bif.mem_i,         m_i);
    end
    if (bif.mem_rw === 1'b1) rw_hi_cnt++;
    if (bif.rsp_valid === 1'b1 && !prev_rv) rsp_cnt++;
    prev_rv = (bif.rsp_valid === 1'b1);
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_cmd(input logic rw, input logic addr, input logic [7:0] wd);
    int n = 0;
    @(posedge clk); #1;
    bif.cmd_valid = 1'b1; bif.cmd_rw = rw; bif.cmd_addr = addr; bif.cmd_wdata = wd;
    @(negedge clk);
    while (bif.cmd_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (bif.cmd_ready !== 1'b1) chk("cmd_accept_timeout", 8'd0, 8'd1);
    @(posedge clk); #1;
    bif.cmd_valid = 1'b0;
    bif.cmd_rw    = 1'($urandom);
    bif.cmd_addr  = 1'($urandom);
    bif.cmd_wdata = 8'($urandom);
  endtask

  task automatic get_rsp(input int hold, output logic [7:0] data, output logic rw);
    int n = 0;
    @(negedge clk);
    while (bif.rsp_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (bif.rsp_valid !== 1'b1) chk("rsp_timeout", 8'd0, 8'd1);
    repeat (hold) @(negedge clk);
    @(posedge clk); #1;
    bif.rsp_ready = 1'b1;
    @(negedge clk);
    data = bif.rsp_rdata;
    rw   = bif.rsp_rw;
    @(posedge clk); #1;
    bif.rsp_ready = 1'b0;
  endtask

  logic [7:0] d;
  logic       r;
  int         saved;

  initial begin
    clear_n = 1'b0;
    bif.cmd_valid = 1'b1; bif.cmd_rw = RW_WRITE; bif.cmd_addr = 1'b1;
    bif.cmd_wdata = 8'hAA; bif.rsp_ready = 1'b0;

    // Reset with a command pending: nothing accepted.
    repeat (2) begin
      @(posedge clk); @(negedge clk);
      chk("rst_cmd_ready", 8'(bif.cmd_ready), 8'd1);
      chk("rst_rsp_valid", 8'(bif.rsp_valid), 8'd0);
      chk("rst_mem_rw",    8'(bif.mem_rw),    8'd0);
    end
    @(posedge clk); #1;
    bif.cmd_valid = 1'b0;
    clear_n = 1'b1;

    // Write 25 to addr 1, read it back; write pulse is exactly WR_LEN cycles.
    rw_hi_cnt = 0;
    do_cmd(RW_WRITE, 1'b1, 8'h25);
    get_rsp(0, d, r);
    chk("wr25_rsp_rw", 8'(r), 8'd1);
    chk("wr25_rdata",  d, 8'h00);
    chk("wr_pulse_len", 8'(rw_hi_cnt), 8'(WR_LEN_T));
    do_cmd(RW_READ, 1'b1, 8'h00);
    get_rsp(0, d, r);
    chk("rd25_rdata",  d, 8'h25);
    chk("rd25_rsp_rw", 8'(r), 8'd0);

    // Two words, no cross-word disturbance.
    do_cmd(RW_WRITE, 1'b0, 8'h07); get_rsp(0, d, r);
    do_cmd(RW_WRITE, 1'b1, 8'h76); get_rsp(1, d, r);
    do_cmd(RW_READ,  1'b0, 8'h00); get_rsp(0, d, r);
    chk("rd07", d, 8'h07);
    do_cmd(RW_READ,  1'b1, 8'h00); get_rsp(2, d, r);
    chk("rd76", d, 8'h76);

    // A read with wdata=FF must not write.
    rw_hi_cnt = 0;
    do_cmd(RW_READ, 1'b0, 8'hFF); get_rsp(0, d, r);
    chk("rd_no_pulse", 8'(rw_hi_cnt), 8'd0);
    do_cmd(RW_READ, 1'b0, 8'h00); get_rsp(0, d, r);
    chk("rd_prior_val", d, 8'h07);

    // Backpressure: response held while a new write waits unaccepted.
    do_cmd(RW_WRITE, 1'b0, 8'h3A); get_rsp(0, d, r);
    do_cmd(RW_READ,  1'b0, 8'h00);
    while (bif.rsp_valid !== 1'b1) @(negedge clk);
    @(posedge clk); #1;
    bif.cmd_valid = 1'b1; bif.cmd_rw = RW_WRITE; bif.cmd_addr = 1'b0; bif.cmd_wdata = 8'hC3;
    rw_hi_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid", 8'(bif.rsp_valid), 8'd1);
      chk("bp_rdata",     bif.rsp_rdata,     8'h3A);
      chk("bp_cmd_ready", 8'(bif.cmd_ready), 8'd0);
    end
    chk("bp_no_write", 8'(rw_hi_cnt), 8'd0);
    @(posedge clk); #1;
    bif.cmd_valid = 1'b0;
    get_rsp(0, d, r);
    chk("bp_final", d, 8'h3A);

    // Reset in the middle of a write: pulse ends, no response.
    do_cmd(RW_WRITE, 1'b0, 8'h3A);
    saved = rsp_cnt;
    @(posedge clk); #1;
    clear_n = 1'b0;
    @(negedge clk);
    chk("mw_rw_before", 8'(bif.mem_rw), 8'd1);
    @(posedge clk); #1;
    clear_n = 1'b1;
    @(negedge clk);
    chk("mw_rw_after",  8'(bif.mem_rw),    8'd0);
    chk("mw_cmd_ready", 8'(bif.cmd_ready), 8'd1);
    repeat (6) @(negedge clk);
    chk("mw_no_rsp", 8'(rsp_cnt - saved), 8'd0);

    // Randomized traffic checked by the model.
    for (int k = 0; k < 40; k++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      do_cmd(1'($urandom), 1'($urandom), 8'($urandom));
      get_rsp(int'($urandom_range(0, 3)), d, r);
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected done");
    $fatal(1);
  end

endmodule
